// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 8'h00;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    // One prefetch queue slot: the instruction and the byte address it came from.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] pc;
        logic [INSTR_W-1:0]    instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        Q_EMPTY,
        Q_PARTIAL,
        Q_FULL
    } q_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with a same-cycle flush.
//
// state     | meaning
// Q_EMPTY   | no entries; head is not meaningful
// Q_PARTIAL | at least one entry, room for more
// Q_FULL    | DEPTH entries; push only accepted alongside a pop
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    q_state_e      state_q;
    q_state_e      state_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (state_q == Q_FULL);
    assign empty   = (state_q == Q_EMPTY);
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign head    = mem[rd_ptr];

    // Next occupancy and the state it implies; flush wins over push/pop.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
        if (count_d == '0) begin
            state_d = Q_EMPTY;
        end else if (count_d == CW'(DEPTH)) begin
            state_d = Q_FULL;
        end else begin
            state_d = Q_PARTIAL;
        end
    end

    // Occupancy and state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            state_q <= Q_EMPTY;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, instruction memory request and branch redirect in front
// of the prefetch queue feeding decode. ADDR_W must match the entry width
// in fetch_pkg.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] target_aligned;
    logic              q_full;
    logic              q_empty;
    logic              push;
    logic              pop;
    fetch_entry_t      din;
    fetch_entry_t      head;

    assign imem_addr      = pc_q;
    assign target_aligned = branch_target & ~ADDR_W'(3);
    assign id_valid       = !q_empty;
    assign pop            = id_valid && id_ready;
    assign push           = fetch_en && !branch_taken && (!q_full || pop);
    assign din            = '{pc: pc_q, instr: imem_instr};
    assign id_instr       = q_empty ? NOP : head.instr;
    assign id_pc          = q_empty ? '0 : head.pc;

    // PC: redirect beats sequential advance; wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (branch_taken) begin
            pc_q <= target_aligned;
        end else if (push) begin
            pc_q <= pc_q + ADDR_W'(4);
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .flush (branch_taken),
        .din   (din),
        .full  (q_full),
        .empty (q_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an expected-PC scoreboard.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [7:0]  id_pc;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb [$];

    always #5 clk = ~clk;

    // Memory word i holds 32'hE000_0000 + i.
    function automatic logic [31:0] word_at(input logic [7:0] a);
        return 32'hE000_0000 + {26'd0, a[7:2]};
    endfunction

    assign imem_instr = word_at(imem_addr);

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // At a falling edge: score any handshake against the scoreboard, check
    // gating when idle, then advance to the next falling edge.
    task automatic tick(input string tag);
        logic [7:0] e;
        if (id_valid && id_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_pc"}, {24'd0, id_pc}, {24'd0, e});
            chk({tag, "_instr"}, id_instr, word_at(e));
        end else if (!id_valid) begin
            chk({tag, "_gate_pc"}, {24'd0, id_pc}, 32'd0);
            chk({tag, "_gate_instr"}, id_instr, 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        fetch_en      = 1'b0;
        id_ready      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_pc", {24'd0, id_pc}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);

        // Streaming from reset, one instruction per cycle.
        reset    = 1'b0;
        fetch_en = 1'b1;
        id_ready = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h04); sb.push_back(8'h08);
        @(negedge clk);
        chk("p1_first_valid", {31'd0, id_valid}, 32'd1);
        repeat (3) tick("p1");
        chk("p1_sb_drained", sb.size(), 32'd0);

        // Back-pressure: queue fills, PC holds, then drains in order.
        reset    = 1'b1;
        fetch_en = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        reset    = 1'b0;
        fetch_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("p2_addr_hold", {24'd0, imem_addr}, 32'h08);
        chk("p2_head_hold", {24'd0, id_pc}, 32'h00);
        chk("p2_valid", {31'd0, id_valid}, 32'd1);
        id_ready = 1'b1;
        sb.push_back(8'h00); sb.push_back(8'h04); sb.push_back(8'h08);
        repeat (3) tick("p2");
        chk("p2_sb_drained", sb.size(), 32'd0);

        // Misaligned redirect while the queue is full.
        id_ready      = 1'b0;
        chk("p3_pre_valid", {31'd0, id_valid}, 32'd1);
        branch_taken  = 1'b1;
        branch_target = 8'h41;
        @(negedge clk);
        chk("p3_flush_valid", {31'd0, id_valid}, 32'd0);
        chk("p3_redirect_addr", {24'd0, imem_addr}, 32'h40);
        branch_taken = 1'b0;
        id_ready     = 1'b1;
        sb.delete();
        sb.push_back(8'h40); sb.push_back(8'h44);
        repeat (3) tick("p3");
        chk("p3_sb_drained", sb.size(), 32'd0);

        // Redirect with a coincident pop, then PC wrap past 0xFC.
        branch_taken  = 1'b1;
        branch_target = 8'hF8;
        @(negedge clk);
        chk("p4_flush_valid", {31'd0, id_valid}, 32'd0);
        chk("p4_redirect_addr", {24'd0, imem_addr}, 32'hF8);
        branch_taken = 1'b0;
        sb.delete();
        sb.push_back(8'hF8); sb.push_back(8'hFC); sb.push_back(8'h00);
        repeat (4) tick("p4");
        chk("p4_sb_drained", sb.size(), 32'd0);

        // fetch_en low for three cycles: drain, freeze, resume.
        sb.push_back(8'h04);
        fetch_en = 1'b0;
        tick("p5");
        for (int i = 0; i < 3; i++) begin
            chk("p5_frozen_valid", {31'd0, id_valid}, 32'd0);
            chk("p5_frozen_addr", {24'd0, imem_addr}, 32'h08);
            if (i < 2) tick("p5");
        end
        fetch_en = 1'b1;
        sb.push_back(8'h08); sb.push_back(8'h0C);
        repeat (3) tick("p5");
        chk("p5_sb_drained", sb.size(), 32'd0);

        // Asynchronous reset with a full queue, between clock edges.
        id_ready = 1'b0;
        @(negedge clk);
        chk("p6_pre_valid", {31'd0, id_valid}, 32'd1);
        chk("p6_pre_pc", {24'd0, id_pc}, 32'h10);
        #2 reset = 1'b1;
        #1;
        chk("p6_async_valid", {31'd0, id_valid}, 32'd0);
        chk("p6_async_instr", id_instr, 32'd0);
        chk("p6_async_pc", {24'd0, id_pc}, 32'd0);
        chk("p6_async_addr", {24'd0, imem_addr}, 32'd0);

        // Redirect while fetch is disabled: PC moves, nothing is queued.
        @(negedge clk);
        reset         = 1'b0;
        fetch_en      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 8'h27;
        @(negedge clk);
        chk("p7_redirect_addr", {24'd0, imem_addr}, 32'h24);
        chk("p7_valid", {31'd0, id_valid}, 32'd0);
        branch_taken = 1'b0;
        @(negedge clk);
        chk("p7_no_push", {31'd0, id_valid}, 32'd0);
        chk("p7_addr_hold", {24'd0, imem_addr}, 32'h24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester end of the instruction-memory interface.
- Owns the program counter and drives a word-aligned byte address into the combinational-read instruction memory.
- Captures each returned instruction together with its PC into a small prefetch queue.
- Presents queued instructions to the decode stage over a valid/ready handshake, with branch redirect and flush.
- Sits between instruction memory and the IF/ID boundary of the pipeline.

Parameters:
- ADDR_W, 8, byte-address width; matches the 256-entry instruction memory address port.
- DEPTH, 2, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  1 = fetching allowed; 0 = PC and queue input frozen
- imem_addr  out  ADDR_W  byte address to instruction memory; equals current PC
- imem_instr  in  32  instruction returned combinationally for imem_addr
- branch_taken  in  1  redirect request from execute
- branch_target  in  ADDR_W  redirect byte address
- id_valid  out  1  queue head holds a valid instruction
- id_ready  in  1  decode accepts head this cycle
- id_instr  out  32  head instruction; 32'h0 when id_valid=0
- id_pc  out  ADDR_W  byte address of head instruction; 0 when id_valid=0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. On assertion: pc=RESET_PC, queue count=0, id_valid=0, id_instr=0, id_pc=0, imem_addr=RESET_PC.
- Reset mid-operation discards all queued entries immediately; no partial state survives.
- imem_addr is driven directly from the pc register. It is combinational from state only, never from inputs.
- pop = id_valid && id_ready.
- push = fetch_en && !branch_taken && (count < DEPTH || pop). A push writes {pc, imem_instr} at the tail and advances pc <= pc + 4.
- Latency: an instruction fetched at cycle N appears on id_* after the rising edge ending cycle N. Queue-empty to id_valid latency is 1 cycle.
- Full queue: count==DEPTH and no pop → no push; pc holds; imem_addr holds.
- Full queue with simultaneous pop: push and pop in the same cycle; count unchanged.
- Empty queue: id_valid=0; id_ready is ignored.
- branch_taken has highest priority:
  - Next edge: count=0, pc <= {branch_target[ADDR_W-1:2], 2'b00} (misaligned targets are forced aligned).
  - No push that cycle; a coincident pop is discarded with the flush.
  - id_valid=0 the cycle after; first target instruction valid one cycle later.
- branch_taken while fetch_en=0: redirect still applies; no push.
- PC arithmetic is modulo 2^ADDR_W. 8'hFC + 4 wraps to 8'h00 with no flag.
- Queue pointers wrap modulo DEPTH. count ranges 0..DEPTH, width clog2(DEPTH)+1.
- State machine (derived from count): EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop.
  - FULL→PARTIAL on pop without push.
  - Any state→EMPTY on branch_taken or reset.
- id_instr and id_pc are registered queue contents selected by the head pointer, gated to 0 when empty.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W default.
  - RESET_PC.
  - INSTR_W=32.
  - NOP constant 32'h0.
  - fetch_entry_t = {pc[ADDR_W-1:0], instr[31:0]}.
- One sub-module: fetch_queue, a synchronous FIFO of fetch_entry_t.
  - Ports: push, pop, flush, full, empty, head.
  - Asynchronous active-high reset.
  - The top level holds the PC and the push/redirect logic.

Test Plan:
- Reset then fetch_en=1, id_ready=1, memory word i = 32'hE000_0000+i → id_valid rises 1 cycle after reset release; id_pc sequence 0x00,0x04,0x08, one per cycle, id_instr matching.
- id_ready=0 for 5 cycles after start → queue fills at count=2, imem_addr holds at 0x08, id_pc stays 0x00. id_ready=1 → 0x00,0x04,0x08 delivered in order, none skipped or duplicated.
- branch_taken=1 with branch_target=0x41 while queue full → next cycle id_valid=0 and imem_addr=0x40; following cycle id_pc=0x40.
- Start at pc=0xF8 → id_pc sequence 0xF8,0xFC,0x00 (wrap).
- fetch_en=0 for 3 cycles mid-stream with id_ready=1 → queue drains to id_valid=0, pc frozen. Re-enable → resumes at the frozen pc.
- Assert reset asynchronously mid-cycle with count=2 → id_valid, id_instr, id_pc drop to 0 and imem_addr=0x00 before the next clock edge.
